// File: rtl/mlaccel_qpi_pkg.sv
// Shared types and defaults for the QPI slave receive front end.
package mlaccel_qpi_pkg;

  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_RDY_MARGIN = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } qpi_state_e;

  typedef struct packed {
    logic       first;
    logic [7:0] data;
  } qpi_payload_t;

  localparam int PAYLOAD_W = $bits(qpi_payload_t);

endpackage

// File: rtl/mlaccel_qpi_fifo.sv
// Synchronous show-ahead FIFO; an extra pointer MSB separates full from empty.
module mlaccel_qpi_fifo
  import mlaccel_qpi_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = PAYLOAD_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      free
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign free    = DEPTH_W - (wr_ptr - rd_ptr);
  assign do_rd   = rd_en & ~empty;
  // A read in the same cycle frees the slot being written, so full is no obstacle.
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so register order inside a block never changes behaviour.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  // NOTE: storage is intentionally not reset; pointers define validity and the
  // consumer side masks the read word while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mlaccel_qpi_rx.sv
// QPI slave receive front end: synchronizes the host bus, packs nibbles into bytes
// and streams them out. Optional counters under MLACCEL_QPI_STATS_EN.
module mlaccel_qpi_rx
  import mlaccel_qpi_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int RDY_MARGIN = DEF_RDY_MARGIN
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        qpi_csb,
  input  logic        qpi_clk,
  input  logic [3:0]  qpi_io,
  output logic        qpi_rdy,
  output logic        qpi_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_first,
  output logic        frame_end
`ifdef MLACCEL_QPI_STATS_EN
  ,
  output logic [15:0] stat_bytes,
  output logic [7:0]  stat_drops
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] RDY_W = (AW + 1)'(RDY_MARGIN);

  // Bit 0 = s1, bit 1 = s2, bit 2 = s3.
  logic [2:0]   csb_sync;
  logic [2:0]   clk_sync;
  logic [3:0]   io_s1;
  logic [3:0]   io_s2;
  logic         clk_rise;
  logic         csb_fall;
  logic         csb_rise;

  qpi_state_e   st;
  qpi_state_e   st_next;
  logic         push;
  logic         latch_hi;
  logic         set_err;

  logic [3:0]   hi_nib;
  logic         first_pend;
  qpi_payload_t push_pl;
  qpi_payload_t rd_pl;
  logic         pop;
  logic         push_ok;
  logic         drop;
  logic         full;
  logic         empty;
  logic [AW:0]  free;
  logic [AW:0]  free_next;

  // The host holds qpi_io steady around its clock edge, so the data bus only
  // needs to be delayed in step with the qpi_clk synchronizer.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      csb_sync <= 3'b111;
      clk_sync <= 3'b000;
      io_s1    <= '0;
      io_s2    <= '0;
    end else begin
      csb_sync <= {csb_sync[1:0], qpi_csb};
      clk_sync <= {clk_sync[1:0], qpi_clk};
      io_s1    <= qpi_io;
      io_s2    <= io_s1;
    end
  end

  assign clk_rise = clk_sync[1] & ~clk_sync[2];
  assign csb_fall = ~csb_sync[1] & csb_sync[2];
  assign csb_rise = csb_sync[1] & ~csb_sync[2];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) st <= IDLE;
    else         st <= st_next;
  end

  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    st_next  = st;
    push     = 1'b0;
    latch_hi = 1'b0;
    set_err  = 1'b0;
    unique case (st)
      IDLE: if (csb_fall) st_next = HI;
      HI: begin
        if (csb_rise) begin
          st_next = IDLE;
        end else if (clk_rise) begin
          latch_hi = 1'b1;
          st_next  = LO;
        end
      end
      LO: begin
        if (csb_rise) begin
          set_err = 1'b1;
          st_next = IDLE;
        end else if (clk_rise) begin
          push    = 1'b1;
          st_next = HI;
        end
      end
      default: st_next = IDLE;
    endcase
  end

  assign push_pl   = '{first: first_pend, data: {hi_nib, io_s2}};
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign out_data  = out_valid ? rd_pl.data : 8'h00;
  assign out_first = out_valid & rd_pl.first;

  always_comb begin
    free_next = free;
    if (pop)     free_next = free_next + (AW + 1)'(1);
    if (push_ok) free_next = free_next - (AW + 1)'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hi_nib     <= '0;
      first_pend <= 1'b0;
      qpi_err    <= 1'b0;
      frame_end  <= 1'b0;
      qpi_rdy    <= 1'b0;
    end else begin
      frame_end <= csb_rise;
      qpi_rdy   <= (free_next >= RDY_W);
      if (latch_hi) hi_nib <= io_s2;
      if (csb_fall)  first_pend <= 1'b1;
      else if (push) first_pend <= 1'b0;
      if (csb_fall)            qpi_err <= 1'b0;
      else if (set_err | drop) qpi_err <= 1'b1;
    end
  end

  mlaccel_qpi_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (push),
    .wr_data (push_pl),
    .rd_en   (pop),
    .rd_data (rd_pl),
    .full    (full),
    .empty   (empty),
    .free    (free)
  );

`ifdef MLACCEL_QPI_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stat_bytes <= '0;
      stat_drops <= '0;
    end else begin
      if (push_ok) stat_bytes <= stat_bytes + 16'd1;
      if (drop && stat_drops != 8'hFF) stat_drops <= stat_drops + 8'd1;
    end
  end
`endif

endmodule
